knight_anim: RTL and testbench

KNIGHT_ANIM -- requirements
Module: knight_anim

---
 rtl/knight_anim.sv | 186 ++++++++++++++++++
 tb/tb_knight_anim.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/knight_anim.sv
// Knight sprite animation controller: picks the sprite ROM frame for the
// player's current action, runs the attack swing, and blinks after damage.
module knight_anim #(
   parameter int IDLE_TICKS = 8,
   parameter int WALK_TICKS = 4,
   parameter int ATK_TICKS  = 3,
   parameter int HURT_TICKS = 60
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic [3:0] Player_Status,
   input  logic       Inverse,
   input  logic [3:0] Player_Life,
   output logic [4:0] Sprite_Index,
   output logic       Mirror,
   output logic       Flash,
   output logic       Attack_Active,
   output logic       Attack_Done,
   output logic       Dead
);

   // Jump/fall hold frame 0 for a fixed 4 ticks before settling on frame 1.
   localparam int AIR_TICKS = 4;
   localparam int TICK_MAX_A = (IDLE_TICKS > WALK_TICKS) ? IDLE_TICKS : WALK_TICKS;
   localparam int TICK_MAX_B = (ATK_TICKS > AIR_TICKS) ? ATK_TICKS : AIR_TICKS;
   localparam int TICK_MAX   = (TICK_MAX_A > TICK_MAX_B) ? TICK_MAX_A : TICK_MAX_B;
   localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int HW = $clog2(HURT_TICKS + 1);

   localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TICKS - 1);
   localparam logic [TW-1:0] WALK_LAST = TW'(WALK_TICKS - 1);
   localparam logic [TW-1:0] ATK_LAST  = TW'(ATK_TICKS - 1);
   localparam logic [TW-1:0] AIR_LAST  = TW'(AIR_TICKS - 1);
   localparam logic [HW-1:0] HURT_LOAD = HW'(HURT_TICKS);

   typedef enum logic [2:0] {IDLE, WALK, JUMP, FALL, ATTACK, DEAD} state_t;

   state_t          state_reg, state_next, mapped;
   logic [2:0]      frame_reg, frame_next;
   logic [TW-1:0]   tick_reg, tick_next;
   logic [HW-1:0]   hurt_cnt, hurt_cnt_next;
   logic [3:0]      life_q;
   logic            capture;
   logic [4:0]      base_next, index_next;
   logic            mirror_next, flash_next, active_next, done_next, dead_next;

   function automatic state_t map_status(input logic [3:0] s);
      case (s)
         4'd1:    return WALK;
         4'd2:    return JUMP;
         4'd3:    return FALL;
         4'd4:    return ATTACK;
         default: return IDLE;
      endcase
   endfunction

   // Next state, frame and tick; capture marks the tick a new swing begins.
   always_comb begin
      state_next = state_reg;
      frame_next = frame_reg;
      tick_next  = tick_reg;
      capture    = 1'b0;
      mapped     = map_status(Player_Status);
      if (Player_Life == 4'd0) begin
         state_next = DEAD;
         frame_next = 3'd0;
         tick_next  = '0;
      end else begin
         case (state_reg)
            DEAD: begin
               state_next = IDLE;
               frame_next = 3'd0;
               tick_next  = '0;
            end
            ATTACK: begin
               if (tick_reg == ATK_LAST) begin
                  tick_next = '0;
                  if (frame_reg == 3'd4) begin
                     state_next = mapped;
                     frame_next = 3'd0;
                     capture    = (mapped == ATTACK);
                  end else begin
                     frame_next = frame_reg + 3'd1;
                  end
               end else begin
                  tick_next = tick_reg + TW'(1);
               end
            end
            default: begin
               if (mapped != state_reg) begin
                  state_next = mapped;
                  frame_next = 3'd0;
                  tick_next  = '0;
                  capture    = (mapped == ATTACK);
               end else begin
                  case (state_reg)
                     IDLE: begin
                        if (tick_reg == IDLE_LAST) begin
                           tick_next  = '0;
                           frame_next = (frame_reg == 3'd3) ? 3'd0 : frame_reg + 3'd1;
                        end else begin
                           tick_next = tick_reg + TW'(1);
                        end
                     end
                     WALK: begin
                        if (tick_reg == WALK_LAST) begin
                           tick_next  = '0;
                           frame_next = (frame_reg == 3'd5) ? 3'd0 : frame_reg + 3'd1;
                        end else begin
                           tick_next = tick_reg + TW'(1);
                        end
                     end
                     JUMP, FALL: begin
                        if (frame_reg == 3'd0) begin
                           if (tick_reg == AIR_LAST) begin
                              tick_next  = '0;
                              frame_next = 3'd1;
                           end else begin
                              tick_next = tick_reg + TW'(1);
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   // Hurt window and the output values that will be registered this tick.
   always_comb begin
      hurt_cnt_next = '0;
      if (Player_Life == 4'd0)
         hurt_cnt_next = '0;
      else if (Player_Life < life_q)
         hurt_cnt_next = HURT_LOAD;
      else if (hurt_cnt != '0)
         hurt_cnt_next = hurt_cnt - HW'(1);

      case (state_next)
         WALK:    base_next = 5'd4;
         JUMP:    base_next = 5'd10;
         FALL:    base_next = 5'd12;
         ATTACK:  base_next = 5'd14;
         DEAD:    base_next = 5'd19;
         default: base_next = 5'd0;
      endcase
      index_next  = base_next + {2'b00, frame_next};
      mirror_next = (state_next == ATTACK && !capture && state_reg == ATTACK) ? Mirror : Inverse;
      flash_next  = (state_next != DEAD) && (hurt_cnt_next != '0) && hurt_cnt_next[2];
      active_next = (state_next == ATTACK) && (frame_next == 3'd1 || frame_next == 3'd2);
      done_next   = (state_next == ATTACK) && (frame_next == 3'd4) && (tick_next == ATK_LAST);
      dead_next   = (state_next == DEAD);
   end

   // State, counters and registered outputs; reset aborts any swing or blink.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= IDLE;
         frame_reg     <= 3'd0;
         tick_reg      <= '0;
         hurt_cnt      <= '0;
         life_q        <= 4'd0;
         Sprite_Index  <= 5'd0;
         Mirror        <= 1'b0;
         Flash         <= 1'b0;
         Attack_Active <= 1'b0;
         Attack_Done   <= 1'b0;
         Dead          <= 1'b0;
      end else begin
         state_reg     <= state_next;
         frame_reg     <= frame_next;
         tick_reg      <= tick_next;
         hurt_cnt      <= hurt_cnt_next;
         life_q        <= Player_Life;
         Sprite_Index  <= index_next;
         Mirror        <= mirror_next;
         Flash         <= flash_next;
         Attack_Active <= active_next;
         Attack_Done   <= done_next;
         Dead          <= dead_next;
      end
   end

endmodule

// File: tb/tb_knight_anim.sv
// Directed bench for knight_anim: walk loop, attack swings, hurt blink,
// death, jump hold and reset abort, with hand-derived expectations.
module tb_knight_anim;

   logic       frame_clk = 1'b0;
   logic       Reset_n;
   logic [3:0] Player_Status;
   logic       Inverse;
   logic [3:0] Player_Life;
   logic [4:0] Sprite_Index;
   logic       Mirror, Flash, Attack_Active, Attack_Done, Dead;

   int total = 0;
   int bad   = 0;
   int act_cnt, done_cnt, h;

   knight_anim dut (
      .frame_clk     (frame_clk),
      .Reset_n       (Reset_n),
      .Player_Status (Player_Status),
      .Inverse       (Inverse),
      .Player_Life   (Player_Life),
      .Sprite_Index  (Sprite_Index),
      .Mirror        (Mirror),
      .Flash         (Flash),
      .Attack_Active (Attack_Active),
      .Attack_Done   (Attack_Done),
      .Dead          (Dead)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   function automatic logic flash_of(input int hv);
      logic [31:0] v;
      v = hv;
      return (hv > 0) && v[2];
   endfunction

   initial begin
      Reset_n = 1'b0; Player_Status = 4'd1; Inverse = 1'b0; Player_Life = 4'd2;
      #12;
      chk("rst_index", Sprite_Index, 0);
      chk("rst_mirror", Mirror, 0);
      chk("rst_flash", Flash, 0);
      chk("rst_active", Attack_Active, 0);
      chk("rst_done", Attack_Done, 0);
      chk("rst_dead", Dead, 0);
      Reset_n = 1'b1;

      // walk loop with Mirror following Inverse
      for (int i = 1; i <= 30; i++) begin
         Inverse = ((i / 3) % 2) != 0;
         step();
         chk("walk_index", Sprite_Index, 4 + ((i - 1) / 4) % 6);
         chk("walk_mirror", Mirror, Inverse);
         chk("walk_flash", Flash, 0);
         $display("walk tick %0d index=%0d mirror=%0d", i, Sprite_Index, Mirror);
      end

      // single-tick attack request, then idle
      Inverse = 1'b0; Player_Status = 4'd4; act_cnt = 0; done_cnt = 0;
      for (int j = 1; j <= 16; j++) begin
         step();
         if (j == 1) Player_Status = 4'd0;
         act_cnt  += int'(Attack_Active);
         done_cnt += int'(Attack_Done);
         chk("swing_index", Sprite_Index, (j <= 15) ? 14 + (j - 1) / 3 : 0);
         chk("swing_active", Attack_Active, (j >= 4 && j <= 9) ? 1 : 0);
         chk("swing_done", Attack_Done, (j == 15) ? 1 : 0);
         $display("swing tick %0d index=%0d active=%0d done=%0d", j, Sprite_Index, Attack_Active, Attack_Done);
      end
      chk("swing_active_ticks", act_cnt, 6);
      chk("swing_done_pulses", done_cnt, 1);

      // held attack: back-to-back swings, Mirror latched per swing
      Player_Status = 4'd4; Inverse = 1'b0;
      for (int j = 1; j <= 31; j++) begin
         if (j == 5)  Inverse = 1'b1;
         if (j == 20) Inverse = 1'b0;
         if (j == 31) Player_Status = 4'd0;
         step();
         chk("held_index", Sprite_Index, (j <= 30) ? 14 + ((j - 1) % 15) / 3 : 0);
         chk("held_mirror", Mirror, (j >= 16 && j <= 30) ? 1 : 0);
         chk("held_done", Attack_Done, (j == 15 || j == 30) ? 1 : 0);
         $display("held tick %0d index=%0d mirror=%0d done=%0d", j, Sprite_Index, Mirror, Attack_Done);
      end

      // life 2 -> 1: 60-tick blink window
      Player_Status = 4'd0; Player_Life = 4'd1;
      for (int k = 1; k <= 62; k++) begin
         step();
         h = (k <= 60) ? 61 - k : 0;
         chk("hurt_flash", Flash, flash_of(h));
         $display("hurt tick %0d flash=%0d", k, Flash);
      end
      // a life increase must not blink
      Player_Life = 4'd3;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("gain_flash", Flash, 0);
         $display("gain tick %0d flash=%0d", k, Flash);
      end
      // second drop at tick 30 reloads the window
      Player_Life = 4'd2;
      for (int k = 1; k <= 95; k++) begin
         if (k == 30) Player_Life = 4'd1;
         step();
         h = (k < 30) ? 61 - k : ((k <= 90) ? 90 - k : 0);
         chk("reload_flash", Flash, flash_of(h));
         $display("reload tick %0d flash=%0d", k, Flash);
      end

      // death during attack frame 2
      Player_Status = 4'd4;
      for (int j = 1; j <= 7; j++) begin
         step();
         if (j == 1) Player_Status = 4'd0;
      end
      chk("pre_death_index", Sprite_Index, 16);
      chk("pre_death_active", Attack_Active, 1);
      Player_Life = 4'd0;
      step();
      chk("death_dead", Dead, 1);
      chk("death_index", Sprite_Index, 19);
      chk("death_active", Attack_Active, 0);
      chk("death_done", Attack_Done, 0);
      chk("death_flash", Flash, 0);
      $display("death index=%0d dead=%0d", Sprite_Index, Dead);
      Player_Status = 4'd4;
      for (int j = 1; j <= 10; j++) begin
         step();
         chk("dead_hold_dead", Dead, 1);
         chk("dead_hold_index", Sprite_Index, 19);
         chk("dead_hold_done", Attack_Done, 0);
         $display("dead tick %0d index=%0d done=%0d", j, Sprite_Index, Attack_Done);
      end
      Player_Status = 4'd0; Player_Life = 4'd2;
      step();
      chk("revive_dead", Dead, 0);
      chk("revive_index", Sprite_Index, 0);
      chk("revive_flash", Flash, 0);
      $display("revive index=%0d dead=%0d flash=%0d", Sprite_Index, Dead, Flash);

      // jump hold then out-of-range status
      Player_Status = 4'd2;
      for (int j = 1; j <= 10; j++) begin
         step();
         chk("jump_index", Sprite_Index, (j <= 4) ? 10 : 11);
         $display("jump tick %0d index=%0d", j, Sprite_Index);
      end
      Player_Status = 4'd9;
      step();
      chk("status9_index", Sprite_Index, 0);
      $display("status9 index=%0d", Sprite_Index);

      // reset mid-attack and mid-blink
      Inverse = 1'b1; Player_Status = 4'd4; Player_Life = 4'd1;
      for (int j = 1; j <= 7; j++) begin
         step();
         if (j == 1) Player_Status = 4'd0;
      end
      chk("pre_rst_flash", Flash, 1);
      chk("pre_rst_active", Attack_Active, 1);
      chk("pre_rst_index", Sprite_Index, 16);
      chk("pre_rst_mirror", Mirror, 1);
      Reset_n = 1'b0;
      #1;
      chk("abort_index", Sprite_Index, 0);
      chk("abort_active", Attack_Active, 0);
      chk("abort_flash", Flash, 0);
      chk("abort_mirror", Mirror, 0);
      chk("abort_dead", Dead, 0);
      $display("abort index=%0d active=%0d flash=%0d", Sprite_Index, Attack_Active, Flash);
      #2;
      Reset_n = 1'b1; Inverse = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         step();
         chk("post_rst_flash", Flash, 0);
         chk("post_rst_index", Sprite_Index, 0);
         $display("post reset tick %0d index=%0d flash=%0d", j, Sprite_Index, Flash);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
